redun_mont_sq_ctl: RTL
======================

// Module: redun_mont_sq_ctl
// PURPOSE
//   Sequencer directly upstream of multi_mode_multiplier. Runs repeated
//   Montgomery squarings x <- x^2 * R^-1 mod M. Each iteration drives the
//   multiplier in three one-hot modes: square, multiply-low, multiply-high.
//   It captures the multiplier's registered products and loops the
//   redundant-form result back, for a programmed iteration count.
// PARAMETERS
//   NUM_ELEMENTS  33  words per operand (matches the multiplier)
//   DSP_BIT_LEN   17  bits per redundant word
//   WORD_LEN      16  non-redundant bits per word
//   ITER_W        32  width of the iteration counter
// PORTS
//   i_clk         in   1                  clock
//   i_rst_n       in   1                  async active-low reset
//   i_start       in   1                  start request; accepted only when o_ready=1
//   o_ready       out  1                  1 in IDLE
//   i_iter        in   ITER_W             squarings to perform; sampled at start
//   i_dat         in   [DSP_BIT_LEN] x N  initial x; sampled at start
//   i_modulus     in   [DSP_BIT_LEN] x N  M; sampled at start
//   i_mont_inv    in   [DSP_BIT_LEN] x N  -M^-1 mod R; sampled at start
//   o_valid       out  1                  one-cycle pulse, result on o_dat
//   o_dat         out  [DSP_BIT_LEN] x N  result; held until next accepted start
//   o_mul_ctl     out  3                  to multiplier i_ctl (one-hot or 0)
//   o_mul_dat_a   out  [DSP_BIT_LEN] x N  to multiplier i_dat_a
//   o_mul_dat_b   out  [DSP_BIT_LEN] x N  to multiplier i_dat_b
//   o_mul_add     out  [DSP_BIT_LEN] x N  to multiplier i_add_term
//   i_mul_dat     in   [DSP_BIT_LEN] x 2N from multiplier o_dat (1-cycle registered)
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state=IDLE; o_ready=1; o_valid=0.
//   o_dat, o_mul_* and all internal regs = 0. Reset mid-iteration aborts;
//   no o_valid is issued.
// - All outputs are registered. The multiplier adds 1 cycle, so each phase is
//   2 states: issue (operands on o_mul_*), then wait. In the wait state,
//   i_mul_dat is valid; it is captured and the next operands are loaded on
//   the same edge.
// - States: IDLE, SQ, SQ_W, ML, ML_W, MH, MH_W, DONE.
//   IDLE -(i_start)->
//     iter==0 ? DONE : SQ
//   SQ   : ctl=3'b001; a=b=x; add=0
//   SQ_W : P[0..2N-1] <= i_mul_dat;                 -> ML
//   ML   : ctl=3'b010; a=P[0..N-1]; b=mont_inv; add=0
//   ML_W : q <= i_mul_dat[0..N-1];                  -> MH
//   MH   : ctl=3'b100; a=q; b=modulus; add=P[N..2N-1]
//   MH_W : x <= i_mul_dat[0..N-1]; cnt <= cnt-1;
//          cnt==1 ? DONE : SQ
//   DONE : o_valid=1; o_dat=x;                      -> IDLE
// - o_mul_ctl = 0 in all *_W, IDLE and DONE states, so the multiplier never
//   sees two bits set.
// - Latency from start edge to o_valid: 6*iter+1 cycles. iter==0 gives
//   o_valid 1 cycle after start, with o_dat = i_dat unchanged.
// - o_ready=0 from start acceptance through DONE. i_start while busy is
//   ignored (not queued).
// - o_ready returns to 1 the cycle after DONE. Back-to-back start is legal.
// - x, P and q stay in redundant form. No carry normalisation happens in
//   this block. Word width is DSP_BIT_LEN throughout; the upper bits of
//   i_mul_dat are truncated to DSP_BIT_LEN per word.
// - Iteration counter: ITER_W bits, loaded from i_iter, never wraps.
//   i_iter = all-ones runs the full count.
// TESTING (bench: NUM_ELEMENTS=4, behavioural multiplier model + bignum ref)
// 1. iter=0, i_dat=word-pattern 0x1_0001
//    -> o_valid exactly 1 cycle after start; o_dat==i_dat; o_mul_ctl stays 0.
// 2. iter=1, x=0, any M
//    -> ctl sequence 001,0,010,0,100,0; o_valid at cycle 7; o_dat normalises to 0.
// 3. iter=5, random odd 64-bit M, x<M
//    -> normalised o_dat == x^(2^5) * R^-(2^5-1)... per ref model
//       (x <- x^2*R^-1 mod M, five times); o_valid at cycle 31.
// 4. i_start pulsed at cycles 2 and 4 of a busy run
//    -> ignored; exactly one o_valid; o_ready low until DONE+1.
// 5. i_rst_n low during MH of iteration 2
//    -> all outputs 0 immediately; o_ready=1 after release; a new start runs clean.
// 6. Back-to-back: start asserted in the cycle o_ready returns
//    -> second run accepted; first o_dat held until that edge.

Source files
------------

// File: rtl/redun_mont_sq_ctl.sv
// rtl/redun_mont_sq_ctl.sv - Montgomery squaring sequencer for multi_mode_multiplier
// Drives square / mul-low / mul-high per iteration and feeds the redundant result back.
module redun_mont_sq_ctl #(
    parameter int NUM_ELEMENTS = 33,
    parameter int DSP_BIT_LEN  = 17,
    parameter int WORD_LEN     = 16,
    parameter int ITER_W       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_ready,
    input  logic [ITER_W-1:0]      i_iter,
    input  logic [DSP_BIT_LEN-1:0] i_dat      [NUM_ELEMENTS],
    input  logic [DSP_BIT_LEN-1:0] i_modulus  [NUM_ELEMENTS],
    input  logic [DSP_BIT_LEN-1:0] i_mont_inv [NUM_ELEMENTS],
    output logic                   o_valid,
    output logic [DSP_BIT_LEN-1:0] o_dat      [NUM_ELEMENTS],
    output logic [2:0]             o_mul_ctl,
    output logic [DSP_BIT_LEN-1:0] o_mul_dat_a [NUM_ELEMENTS],
    output logic [DSP_BIT_LEN-1:0] o_mul_dat_b [NUM_ELEMENTS],
    output logic [DSP_BIT_LEN-1:0] o_mul_add   [NUM_ELEMENTS],
    input  logic [DSP_BIT_LEN-1:0] i_mul_dat   [2*NUM_ELEMENTS]
);

    if (WORD_LEN >= DSP_BIT_LEN) begin : g_bad_word_len
        $error("WORD_LEN must leave at least one redundant bit per word");
    end

    typedef logic [DSP_BIT_LEN-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SQ, S_SQ_W, S_ML, S_ML_W, S_MH, S_MH_W, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    word_t             x_q   [NUM_ELEMENTS];
    word_t             x_d   [NUM_ELEMENTS];
    word_t             m_q   [NUM_ELEMENTS];
    word_t             m_d   [NUM_ELEMENTS];
    word_t             inv_q [NUM_ELEMENTS];
    word_t             inv_d [NUM_ELEMENTS];
    word_t             q_q   [NUM_ELEMENTS];
    word_t             q_d   [NUM_ELEMENTS];
    word_t             p_q   [2*NUM_ELEMENTS];
    word_t             p_d   [2*NUM_ELEMENTS];

    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [2:0]        ctl_q, ctl_d;
    word_t             dat_q [NUM_ELEMENTS];
    word_t             dat_d [NUM_ELEMENTS];
    word_t             a_q   [NUM_ELEMENTS];
    word_t             a_d   [NUM_ELEMENTS];
    word_t             b_q   [NUM_ELEMENTS];
    word_t             b_d   [NUM_ELEMENTS];
    word_t             add_q [NUM_ELEMENTS];
    word_t             add_d [NUM_ELEMENTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            ctl_q   <= 3'b000;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                x_q[i]   <= '0;
                m_q[i]   <= '0;
                inv_q[i] <= '0;
                q_q[i]   <= '0;
                dat_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                add_q[i] <= '0;
            end
            for (int i = 0; i < 2*NUM_ELEMENTS; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            m_q     <= m_d;
            inv_q   <= inv_d;
            q_q     <= q_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            dat_q   <= dat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            add_q   <= add_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        m_d     = m_q;
        inv_d   = inv_q;
        q_d     = q_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    x_d     = i_dat;
                    m_d     = i_modulus;
                    inv_d   = i_mont_inv;
                    cnt_d   = i_iter;
                    state_d = (i_iter == '0) ? S_DONE : S_SQ;
                end
            end
            S_SQ:   state_d = S_SQ_W;
            S_SQ_W: begin
                p_d     = i_mul_dat;
                state_d = S_ML;
            end
            S_ML:   state_d = S_ML_W;
            S_ML_W: begin
                for (int i = 0; i < NUM_ELEMENTS; i++) q_d[i] = i_mul_dat[i];
                state_d = S_MH;
            end
            S_MH:   state_d = S_MH_W;
            S_MH_W: begin
                for (int i = 0; i < NUM_ELEMENTS; i++) x_d[i] = i_mul_dat[i];
                cnt_d   = cnt_q - ITER_W'(1);
                state_d = (cnt_q == ITER_W'(1)) ? S_DONE : S_SQ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        ctl_d   = 3'b000;
        dat_d   = (state_d == S_DONE) ? x_d : dat_q;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            a_d[i]   = '0;
            b_d[i]   = '0;
            add_d[i] = '0;
        end
        case (state_d)
            S_SQ: begin
                ctl_d = 3'b001;
                a_d   = x_d;
                b_d   = x_d;
            end
            S_ML: begin
                ctl_d = 3'b010;
                for (int i = 0; i < NUM_ELEMENTS; i++) a_d[i] = p_d[i];
                b_d   = inv_d;
            end
            S_MH: begin
                ctl_d = 3'b100;
                a_d   = q_d;
                b_d   = m_d;
                for (int i = 0; i < NUM_ELEMENTS; i++) add_d[i] = p_d[NUM_ELEMENTS+i];
            end
            default: ctl_d = 3'b000;
        endcase
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_mul_ctl   = ctl_q;
    assign o_dat       = dat_q;
    assign o_mul_dat_a = a_q;
    assign o_mul_dat_b = b_q;
    assign o_mul_add   = add_q;

endmodule
